// File: rtl/frame_stats_reader_if.sv
// Signal bundle for frame_stats_reader: custom-instruction port plus bus-master port.
// master = the reader itself; slave = the CPU / arbiter / memory side.
interface frame_stats_reader_if;
    logic        ciStart;
    logic        ciCke;
    logic [7:0]  ciN;
    logic [31:0] ciValueA;
    logic [31:0] ciValueB;
    logic [31:0] ciResult;
    logic        ciDone;
    logic        requestBus;
    logic        busGrant;
    logic        beginTransactionOut;
    logic [31:0] addressDataOut;
    logic        readNotWriteOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;
    logic        endTransactionOut;
    logic [31:0] addressDataIn;
    logic        dataValidIn;
    logic        endTransactionIn;
    logic        busErrorIn;

    modport master (
        input  ciStart, ciCke, ciN, ciValueA, ciValueB,
        output ciResult, ciDone,
        output requestBus, beginTransactionOut, addressDataOut, readNotWriteOut,
               byteEnablesOut, burstSizeOut, endTransactionOut,
        input  busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn
    );

    modport slave (
        output ciStart, ciCke, ciN, ciValueA, ciValueB,
        input  ciResult, ciDone,
        input  requestBus, beginTransactionOut, addressDataOut, readNotWriteOut,
               byteEnablesOut, burstSizeOut, endTransactionOut,
        output busGrant, addressDataIn, dataValidIn, endTransactionIn, busErrorIn
    );
endinterface

// File: rtl/frame_stats_reader.sv
// DMA reader that burst-reads a grayscale frame (4 pixels/word) and keeps sum/min/max/word count.
// Define FRAME_STATS_THRESHOLD_EN to add a programmable threshold and a count of pixels >= it.
module frame_stats_reader #(
    parameter logic [7:0]  customInstructionId = 8'd0,
    parameter int unsigned maxBurstWords       = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    frame_stats_reader_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQUEST, INIT, RECEIVE, ABORT} stateType;

    localparam logic [15:0] maxBurst = 16'(maxBurstWords);

    stateType    state, nextState;
    logic [31:0] baseAddress, address, pixelSum, heldWord;
    logic [15:0] wordCount, remaining, wordsReceived, burstWords;
    logic [7:0]  pixelMin, pixelMax, pixel;
    logic        busy, error, done, finishing, heldValid;
    logic [31:0] foldSum;
    logic [7:0]  foldMin, foldMax;
    logic [3:0]  command;
    logic        ciSelect, acceptWrite, startAccepted;
    logic        unusedCommandBits;
`ifdef FRAME_STATS_THRESHOLD_EN
    logic [7:0]  threshold;
    logic [31:0] aboveCount, foldAbove;
`endif

    assign command           = bus.ciValueA[3:0];
    assign unusedCommandBits = ^bus.ciValueA[31:4];
    assign ciSelect          = bus.ciStart && bus.ciCke && (bus.ciN == customInstructionId);
    assign bus.ciDone        = ciSelect;
    assign acceptWrite       = ciSelect && !busy;
    assign startAccepted     = acceptWrite && (command == 4'd2);
    assign burstWords        = (remaining > maxBurst) ? maxBurst : remaining;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        // NOTE: default first so every path assigns nextState and no latch is inferred.
        nextState = state;
        case (state)
            IDLE:    if (startAccepted && (wordCount != 16'd0)) nextState = REQUEST;
            REQUEST: if (bus.busGrant) nextState = INIT;
            INIT:    nextState = RECEIVE;
            RECEIVE: begin
                if (bus.busErrorIn)            nextState = ABORT;
                else if (bus.endTransactionIn) nextState = (remaining != 16'd0) ? REQUEST : IDLE;
            end
            ABORT:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Fold the word captured last cycle into the running statistics.
    always_comb begin
        // NOTE: blocking '=' in combinational logic; each loop pass builds on the previous one.
        foldSum = pixelSum;
        foldMin = pixelMin;
        foldMax = pixelMax;
        pixel   = 8'd0;
`ifdef FRAME_STATS_THRESHOLD_EN
        foldAbove = aboveCount;
`endif
        for (int i = 0; i < 4; i++) begin
            pixel   = heldWord[8*i +: 8];
            foldSum = foldSum + {24'd0, pixel};
            if (pixel < foldMin) foldMin = pixel;
            if (pixel > foldMax) foldMax = pixel;
`ifdef FRAME_STATS_THRESHOLD_EN
            if (pixel >= threshold) foldAbove = foldAbove + 32'd1;
`endif
        end
    end

    always_comb begin
        bus.ciResult = 32'd0;
        if (ciSelect) begin
            case (command)
                4'd3:    bus.ciResult = {29'd0, busy, error, done};
                4'd4:    bus.ciResult = pixelSum;
                4'd5:    bus.ciResult = {16'd0, pixelMax, pixelMin};
                4'd6:    bus.ciResult = {16'd0, wordsReceived};
                4'd7:    bus.ciResult = baseAddress;
`ifdef FRAME_STATS_THRESHOLD_EN
                4'd9:    bus.ciResult = aboveCount;
`endif
                default: bus.ciResult = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking '<=' so all registers update together.
            baseAddress   <= '0;
            wordCount     <= '0;
            address       <= '0;
            remaining     <= '0;
            pixelSum      <= '0;
            pixelMin      <= '0;
            pixelMax      <= '0;
            wordsReceived <= '0;
            heldWord      <= '0;
            heldValid     <= 1'b0;
            busy          <= 1'b0;
            error         <= 1'b0;
            done          <= 1'b0;
            finishing     <= 1'b0;
            bus.requestBus          <= 1'b0;
            bus.beginTransactionOut <= 1'b0;
            bus.addressDataOut      <= '0;
            bus.readNotWriteOut     <= 1'b0;
            bus.byteEnablesOut      <= '0;
            bus.burstSizeOut        <= '0;
            bus.endTransactionOut   <= 1'b0;
`ifdef FRAME_STATS_THRESHOLD_EN
            threshold  <= 8'h80;
            aboveCount <= '0;
`endif
        end else begin
            // A datum arriving together with a bus error is discarded.
            heldValid <= (state == RECEIVE) && bus.dataValidIn && !bus.busErrorIn;
            if ((state == RECEIVE) && bus.dataValidIn) heldWord <= bus.addressDataIn;

            if (heldValid) begin
                pixelSum      <= foldSum;
                pixelMin      <= foldMin;
                pixelMax      <= foldMax;
                wordsReceived <= wordsReceived + 16'd1;
`ifdef FRAME_STATS_THRESHOLD_EN
                aboveCount    <= foldAbove;
`endif
            end

            if (acceptWrite && (command == 4'd0)) baseAddress <= {bus.ciValueB[31:2], 2'b00};
            if (acceptWrite && (command == 4'd1)) wordCount   <= bus.ciValueB[15:0];
`ifdef FRAME_STATS_THRESHOLD_EN
            if (ciSelect && (command == 4'd8)) threshold <= bus.ciValueB[7:0];
`endif

            if (startAccepted) begin
                done          <= (wordCount == 16'd0);
                busy          <= (wordCount != 16'd0);
                error         <= 1'b0;
                finishing     <= 1'b0;
                pixelSum      <= '0;
                pixelMin      <= 8'hFF;
                pixelMax      <= 8'h00;
                wordsReceived <= '0;
                address       <= baseAddress;
                remaining     <= wordCount;
`ifdef FRAME_STATS_THRESHOLD_EN
                aboveCount    <= '0;
`endif
            end

            if (state == INIT) begin
                remaining <= remaining - burstWords;
                address   <= address + {14'd0, burstWords, 2'b00};
            end

            // Done waits for the fold pipeline to drain so sum and done are never out of step.
            if ((state == RECEIVE) && bus.endTransactionIn && !bus.busErrorIn && (remaining == 16'd0))
                finishing <= 1'b1;
            if (finishing && !heldValid) begin
                done      <= 1'b1;
                busy      <= 1'b0;
                finishing <= 1'b0;
            end
            if (state == ABORT) begin
                error <= 1'b1;
                busy  <= 1'b0;
            end

            bus.requestBus          <= (nextState == REQUEST);
            bus.beginTransactionOut <= (state == INIT);
            bus.readNotWriteOut     <= (state == INIT);
            bus.byteEnablesOut      <= (state == INIT) ? 4'hF : 4'h0;
            bus.addressDataOut      <= (state == INIT) ? address : 32'd0;
            bus.burstSizeOut        <= (state == INIT) ? 8'(burstWords - 16'd1) : 8'd0;
            bus.endTransactionOut   <= (nextState == ABORT);
        end
    end
endmodule

// File: tb/tb_frame_stats_reader.sv
// Bench for frame_stats_reader: memory/bus slave, spec-level statistics model, per-cycle compare.
module tb_frame_stats_reader;
    logic clock = 1'b0;
    logic reset;

    frame_stats_reader_if ifc();

    frame_stats_reader #(.customInstructionId(8'd0), .maxBurstWords(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (ifc)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  size;
    } burstType;

    int          testsRun = 0;
    int          testsFailed = 0;
    burstType    expBursts[$];
    logic [31:0] seenAddr[$];
    logic [7:0]  seenSize[$];
    int          endPulses = 0;
    int          requestCycles = 0;
    int          errorBeat = -1;
    int          strayReq = 0;
    logic [7:0]  modelThr;
    logic [31:0] expSum, expAbove;
    logic [7:0]  expMin, expMax;
    int          expWords;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Frame contents as a function of byte address.
    function automatic logic [7:0] pixelAt(input logic [31:0] a);
        return a[7:0] ^ {a[11:8], 4'h0};
    endfunction

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        return {pixelAt(a + 32'd3), pixelAt(a + 32'd2), pixelAt(a + 32'd1), pixelAt(a)};
    endfunction

    task automatic modelStats(input logic [31:0] base, input int words);
        logic [7:0] p;
        expSum = 0; expMin = 8'hFF; expMax = 8'h00; expAbove = 0; expWords = words;
        for (int i = 0; i < words * 4; i++) begin
            p = pixelAt(base + 32'(i));
            expSum = expSum + 32'(p);
            if (p < expMin) expMin = p;
            if (p > expMax) expMax = p;
            if (p >= modelThr) expAbove = expAbove + 1;
        end
    endtask

    task automatic modelBursts(input logic [31:0] base, input int count);
        int rem;
        int b;
        logic [31:0] a;
        rem = count; a = base;
        while (rem > 0) begin
            b = (rem > 16) ? 16 : rem;
            expBursts.push_back('{a, 8'(b - 1)});
            rem -= b;
            a += 32'(4 * b);
        end
    endtask

    task automatic ciOp(input logic [7:0] num, input logic [3:0] cmd, input logic [31:0] valueB,
                        output logic [31:0] result);
        @(posedge clock); #1;
        ifc.ciStart = 1'b1; ifc.ciCke = 1'b1; ifc.ciN = num;
        ifc.ciValueA = {28'd0, cmd}; ifc.ciValueB = valueB;
        #2 result = ifc.ciResult;
        @(posedge clock); #1;
        ifc.ciStart = 1'b0; ifc.ciCke = 1'b0; ifc.ciN = 8'd0;
        ifc.ciValueA = 32'd0; ifc.ciValueB = 32'd0;
    endtask

    task automatic ciRead(input logic [3:0] cmd, output logic [31:0] result);
        ciOp(8'd0, cmd, 32'd0, result);
    endtask

    task automatic ciWrite(input logic [3:0] cmd, input logic [31:0] value);
        logic [31:0] ignored;
        ciOp(8'd0, cmd, value, ignored);
    endtask

    task automatic waitIdle(input string tag);
        logic [31:0] r;
        r = 32'h4;
        for (int i = 0; i < 400 && r[2]; i++) ciRead(4'd3, r);
        check({tag, "_busy_clears"}, {29'd0, r[2], 2'd0}, 32'd0);
    endtask

    task automatic checkStats(input string tag, input logic [31:0] expStatus);
        logic [31:0] r;
        ciRead(4'd3, r); check({tag, "_status"}, r, expStatus);
        ciRead(4'd4, r); check({tag, "_sum"}, r, expSum);
        ciRead(4'd5, r); check({tag, "_maxmin"}, r, {16'd0, expMax, expMin});
        ciRead(4'd6, r); check({tag, "_words"}, r, 32'(expWords));
        ciRead(4'd9, r);
`ifdef FRAME_STATS_THRESHOLD_EN
        check({tag, "_above"}, r, expAbove);
`else
        check({tag, "_above"}, r, 32'd0);
`endif
    endtask

    // Memory / bus slave: immediate grant, back-to-back data, optional error and stray beats.
    initial begin : slave
        int beat;
        int len;
        int strayDone;
        logic [31:0] addr;
        beat = 0; len = 0; strayDone = 0; addr = 32'd0;
        ifc.busGrant = 1'b0; ifc.dataValidIn = 1'b0; ifc.endTransactionIn = 1'b0;
        ifc.busErrorIn = 1'b0; ifc.addressDataIn = 32'd0;
        forever begin
            @(posedge clock); #1;
            ifc.dataValidIn = 1'b0; ifc.endTransactionIn = 1'b0;
            ifc.busErrorIn = 1'b0; ifc.addressDataIn = 32'd0;
            ifc.busGrant = ifc.requestBus;
            if (reset) begin
                len = 0;
            end else if (ifc.beginTransactionOut) begin
                addr = ifc.addressDataOut;
                len  = int'(ifc.burstSizeOut) + 1;
                beat = 0;
            end else if (beat < len) begin
                ifc.dataValidIn   = 1'b1;
                ifc.addressDataIn = wordAt(addr + 32'(4 * beat));
                if (beat == errorBeat) begin
                    ifc.busErrorIn = 1'b1;
                    len = 0;
                end else if (beat == len - 1) begin
                    ifc.endTransactionIn = 1'b1;
                end
                beat++;
            end else if (strayReq != strayDone) begin
                ifc.dataValidIn   = 1'b1;
                ifc.addressDataIn = 32'd0;
                strayDone = strayReq;
            end
        end
    end

    // Per-cycle compare of handshake and bus outputs against the model.
    always @(negedge clock) begin : compare
        burstType b;
        logic expSel;
        if (!reset) begin
            expSel = ifc.ciStart && ifc.ciCke && (ifc.ciN == 8'd0);
            check("ciDone", 32'(ifc.ciDone), 32'(expSel));
            if (!expSel) check("ciResult_unselected", ifc.ciResult, 32'd0);
            if (ifc.beginTransactionOut) begin
                check("burst_expected", 32'(expBursts.size() > 0), 32'd1);
                if (expBursts.size() > 0) begin
                    b = expBursts.pop_front();
                    check("burst_addr", ifc.addressDataOut, b.addr);
                    check("burst_size", 32'(ifc.burstSizeOut), 32'(b.size));
                    check("burst_rnw_be", 32'({ifc.readNotWriteOut, ifc.byteEnablesOut}), 32'h1F);
                end
                seenAddr.push_back(ifc.addressDataOut);
                seenSize.push_back(ifc.burstSizeOut);
            end else begin
                check("idle_addr", ifc.addressDataOut, 32'd0);
                check("idle_ctrl", 32'({ifc.readNotWriteOut, ifc.byteEnablesOut, ifc.burstSizeOut}), 32'd0);
            end
            endPulses     += int'(ifc.endTransactionOut);
            requestCycles += int'(ifc.requestBus);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, testsFailed=%0d", testsFailed);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] r;
        int reqBefore;
        int endBefore;
        ifc.ciStart = 1'b0; ifc.ciCke = 1'b0; ifc.ciN = 8'd0;
        ifc.ciValueA = 32'd0; ifc.ciValueB = 32'd0;
        reset = 1'b1;
        modelThr = 8'h80;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        ciRead(4'd3, r); check("reset_status", r, 32'd0);
        ciRead(4'd4, r); check("reset_sum", r, 32'd0);
        ciRead(4'd5, r); check("reset_maxmin", r, 32'd0);
        ciRead(4'd6, r); check("reset_words", r, 32'd0);
        ciRead(4'd7, r); check("reset_base", r, 32'd0);
        ciRead(4'd9, r); check("reset_above", r, 32'd0);
        check("reset_request", 32'(ifc.requestBus), 32'd0);

        // Single 4-word burst at 0x1000, bytes 0x00..0x0F.
        ciWrite(4'd8, 32'h08); modelThr = 8'h08;
        ciWrite(4'd0, 32'h1000);
        ciWrite(4'd1, 32'd4);
        modelBursts(32'h1000, 4); modelStats(32'h1000, 4);
        seenAddr.delete(); seenSize.delete();
        ciWrite(4'd2, 32'd0);
        waitIdle("t1");
        checkStats("t1", 32'd1);
        ciRead(4'd4, r); check("t1_sum_literal", r, 32'd120);
        ciRead(4'd5, r); check("t1_maxmin_literal", r, 32'h0F00);
        ciRead(4'd9, r);
`ifdef FRAME_STATS_THRESHOLD_EN
        check("t1_above_literal", r, 32'd8);
`else
        check("t1_above_literal", r, 32'd0);
`endif
        check("t1_burst_count", 32'(seenSize.size()), 32'd1);
        check("t1_burst_size", 32'(seenSize[0]), 32'd3);
        check("t1_burst_addr", seenAddr[0], 32'h1000);

        // 40 words split into 16/16/8 bursts.
        ciWrite(4'd1, 32'd40);
        modelBursts(32'h1000, 40); modelStats(32'h1000, 40);
        seenAddr.delete(); seenSize.delete();
        reqBefore = requestCycles;
        ciWrite(4'd2, 32'd0);
        waitIdle("t2");
        checkStats("t2", 32'd1);
        ciRead(4'd4, r); check("t2_sum_literal", r, 32'd12720);
        ciRead(4'd5, r); check("t2_maxmin_literal", r, 32'h9F00);
        check("t2_burst_count", 32'(seenSize.size()), 32'd3);
        check("t2_size0", 32'(seenSize[0]), 32'd15);
        check("t2_size1", 32'(seenSize[1]), 32'd15);
        check("t2_size2", 32'(seenSize[2]), 32'd7);
        check("t2_addr1", seenAddr[1], 32'h1040);
        check("t2_addr2", seenAddr[2], 32'h1080);
        check("t2_request_cycles", 32'(requestCycles - reqBefore), 32'd3);

        // Bus error on the second datum of a 4-word burst; unaligned base is truncated.
        ciWrite(4'd0, 32'h2003);
        ciWrite(4'd1, 32'd4);
        modelBursts(32'h2000, 4); modelStats(32'h2000, 1);
        errorBeat = 1;
        endBefore = endPulses;
        ciWrite(4'd2, 32'd0);
        waitIdle("t3");
        errorBeat = -1;
        checkStats("t3", 32'd2);
        check("t3_end_pulses", 32'(endPulses - endBefore), 32'd1);
        ciRead(4'd6, r); check("t3_words_literal", r, 32'd1);
        ciRead(4'd7, r); check("t3_base_aligned", r, 32'h2000);
        check("t3_bursts_consumed", 32'(expBursts.size()), 32'd0);

        // Zero-length start completes without touching the bus.
        ciWrite(4'd1, 32'd0);
        modelStats(32'h2000, 0);
        reqBefore = requestCycles;
        ciWrite(4'd2, 32'd0);
        checkStats("t4", 32'd1);
        ciRead(4'd5, r); check("t4_maxmin_literal", r, 32'h00FF);
        check("t4_no_request", 32'(requestCycles - reqBefore), 32'd0);

        // Writes and start while busy are ignored.
        ciWrite(4'd0, 32'h1000);
        ciWrite(4'd1, 32'd40);
        modelBursts(32'h1000, 40); modelStats(32'h1000, 40);
        ciWrite(4'd2, 32'd0);
        ciRead(4'd3, r); check("t5_busy", r, 32'h4);
        ciWrite(4'd0, 32'h5000);
        ciWrite(4'd1, 32'd3);
        ciWrite(4'd2, 32'd0);
        ciRead(4'd7, r); check("t5_base_kept", r, 32'h1000);
        waitIdle("t5");
        checkStats("t5", 32'd1);
        ciOp(8'h01, 4'd7, 32'd0, r); check("t5_other_ci_reads_zero", r, 32'd0);
        ciOp(8'h01, 4'd0, 32'h7000, r);
        ciRead(4'd7, r); check("t5_other_ci_no_write", r, 32'h1000);

        // Stray data while idle, then a burst sequence that wraps past 2^32.
        strayReq++;
        repeat (4) @(posedge clock);
        ciRead(4'd6, r); check("t6_stray_ignored", r, 32'd40);
        ciWrite(4'd0, 32'hFFFF_FFC0);
        ciWrite(4'd1, 32'd20);
        modelBursts(32'hFFFF_FFC0, 20); modelStats(32'hFFFF_FFC0, 20);
        seenAddr.delete(); seenSize.delete();
        ciWrite(4'd2, 32'd0);
        waitIdle("t6");
        checkStats("t6", 32'd1);
        check("t6_wrap_addr", seenAddr[1], 32'h0000_0000);

        // Reset in the middle of a burst.
        ciWrite(4'd0, 32'h1000);
        ciWrite(4'd1, 32'd40);
        modelBursts(32'h1000, 40);
        endBefore = endPulses;
        ciWrite(4'd2, 32'd0);
        repeat (8) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        expBursts.delete();
        modelThr = 8'h80;
        check("t7_request_dropped", 32'(ifc.requestBus), 32'd0);
        ciRead(4'd3, r); check("t7_status", r, 32'd0);
        ciRead(4'd6, r); check("t7_words", r, 32'd0);
        ciRead(4'd7, r); check("t7_base", r, 32'd0);
        check("t7_no_end_pulse", 32'(endPulses - endBefore), 32'd0);

        // Full transfer after reset; threshold is back at its reset value.
        ciWrite(4'd0, 32'h1000);
        ciWrite(4'd1, 32'd40);
        modelBursts(32'h1000, 40); modelStats(32'h1000, 40);
        ciWrite(4'd2, 32'd0);
        waitIdle("t8");
        checkStats("t8", 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/frame_stats_reader.md
Name: frame_stats_reader

Overview:
- Bus-master DMA reader downstream of the camera grabber; burst-reads a grayscale frame buffer (4 pixels/word, byte 0 = first pixel) from shared memory.
- Computes per-frame pixel statistics: sum, min, max, word count.
- Controlled and read back via one custom instruction; lets the CPU get exposure/brightness data without touching pixels.

Parameters:
- customInstructionId, 8'd0, CI number this block responds to
- maxBurstWords, 16, largest read burst in words (power of two, 1..256)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- ciStart, ciCke  in  1 each  CI handshake
- ciN  in  8  CI number
- ciValueA  in  32  command select [3:0]
- ciValueB  in  32  write operand
- ciResult  out  32  read data; 0 when not selected
- ciDone  out  1  = ciStart & ciCke & (ciN==customInstructionId); combinational, single cycle
- requestBus  out  1  high while in REQUEST
- busGrant  in  1  arbiter grant
- beginTransactionOut  out  1  one-cycle transaction start
- addressDataOut  out  32  burst address during begin, else 0
- readNotWriteOut  out  1  high with beginTransactionOut, else 0
- byteEnablesOut  out  4  4'hF with begin, else 0
- burstSizeOut  out  8  words-1 with begin, else 0
- endTransactionOut  out  1  driven only on error abort
- addressDataIn  in  32  read data
- dataValidIn  in  1  read data valid
- endTransactionIn  in  1  slave ends burst
- busErrorIn  in  1  bus error

Behaviour:
- Registered bus outputs, all 0 after reset, like the rest of the bus logic.
- CI commands (ciValueA[3:0]):
  - 0: write base address. Value is {ciValueB[31:2],2'b00}.
  - 1: write word count. Value is ciValueB[15:0].
  - 2: start.
  - 3: read status {29'd0, busy, error, done}.
  - 4: read sum.
  - 5: read {16'd0, max, min}.
  - 6: read words received.
  - 7: read base address.
  - Others read 0.
- Commands 0, 1 and 2 are ignored while busy. Reset clears base, count, sum, min, max, words and flags.
- Start:
  - Clears done and error, sum=0, words=0, min=8'hFF, max=8'h00.
  - Loads address=base and remaining=count.
  - If count==0, sets done immediately and stays in IDLE.
- States: IDLE, REQUEST, INIT, RECEIVE, ABORT.
  - IDLE -> REQUEST on accepted start with count!=0.
  - REQUEST -> INIT on busGrant.
  - INIT, one cycle:
    - Next cycle beginTransactionOut=1, readNotWriteOut=1, byteEnablesOut=4'hF, addressDataOut=address, burstSizeOut=burst-1.
    - burst = min(remaining, maxBurstWords).
    - remaining -= burst; address += 4*burst.
    - -> RECEIVE.
  - RECEIVE:
    - Each dataValidIn cycle: register the word, and in the next cycle fold its 4 bytes into sum, min and max, then words+=1.
    - endTransactionIn -> REQUEST if remaining!=0, else IDLE.
    - busErrorIn has priority over endTransactionIn -> ABORT.
  - ABORT: endTransactionOut=1 for exactly one cycle; set error, clear busy; -> IDLE. Done stays 0.
- Timing and flags:
  - busy=1 from accepted start until return to IDLE.
  - done is set in the cycle after the final datum is accumulated, so status reads never show done with a stale sum.
- Arithmetic:
  - Sum is 32-bit, no overflow possible (max 65535*4*255).
  - Min/max use unsigned 8-bit compares.
  - Address wraps modulo 2^32.
- Edge cases:
  - dataValidIn outside RECEIVE is ignored.
  - dataValidIn and endTransactionIn in the same cycle: the datum is counted.
  - A CI read in the same cycle as an update returns the pre-update value.
  - Reset mid-burst returns to IDLE immediately and drops requestBus; no endTransactionOut is issued.

Optional Feature:
- Macro: FRAME_STATS_THRESHOLD_EN.
- With the macro:
  - Command 8 writes threshold = ciValueB[7:0] (reset 8'h80).
  - Command 9 reads the 32-bit count of pixels >= threshold, cleared on start and updated with the other statistics.
- Without the macro: command 8 is ignored, command 9 reads 0, and no threshold logic is generated.

Test Plan:
- Base=0x1000, count=4, memory bytes 0x00..0x0F, burst granted immediately:
  - One burst, burstSizeOut=3, address 0x1000.
  - sum=120, {max,min}=0x0F00, words=4, status=3'b001.
- count=40, maxBurstWords=16: three bursts with burstSizeOut 15, 15, 7 at 0x1000, 0x1040, 0x1080; words=40, done=1.
- busErrorIn during the 2nd datum of a 4-word burst: endTransactionOut pulses once; status=3'b010; words=1.
- count=0 start: no requestBus; status=3'b001 on the next cycle.
- Start or base write while busy: ignored; a read of command 7 still returns the original base; the transfer completes unchanged.
- FRAME_STATS_THRESHOLD_EN with threshold=0x08 on the first test's data: command 9 returns 8. Without the macro it returns 0.
